sm_addsub_seq: RTL and testbench
================================

# sm_addsub_seq

Parametrised, registered sign-magnitude adder/subtractor with start/done handshake, accumulate mode, saturation and status flags. It is the next-generation arithmetic unit of the datapath, replacing fixed 3-bit combinational add/sub. Operands and result share one width, with the sign in the MSB. A controller issues one operation at a time and samples the result when `done` pulses.

## Interface
Parameters:
- `W`, default 8: total operand/result width; bit W-1 is the sign, bits W-2:0 are the magnitude. Legal range is W ≥ 3.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only when `busy`=0.
- `op_sub`  in  1  0 = A+B, 1 = A−B (invert sign of B).
- `acc`  in  1  1 = use the held `result` as A; `a` is ignored.
- `a`  in  W  operand A, sign-magnitude.
- `b`  in  W  operand B, sign-magnitude.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; `result` and the flags are valid from this cycle onward.
- `result`  out  W  sign-magnitude result, held until the next `done`.
- `zero`  out  1  result magnitude == 0.
- `neg`  out  1  result sign bit (always 0 when `zero`=1).
- `ovf`  out  1  magnitude saturated.

## Operation
- FSM states and transitions:
  - IDLE → EXEC on `start`.
  - EXEC → FIX unconditionally.
  - FIX → DONE unconditionally.
  - DONE → EXEC if `start`, otherwise DONE → IDLE.
- Operand capture:
  - Operands, `op_sub` and `acc` are captured at the accepting edge.
  - If `op_sub`=1, the captured sign of B is inverted.
- EXEC, magnitude arithmetic (sub-module), with M = W−1 bits:
  - Equal signs: sum = magA + magB on M+1 bits; result sign = common sign.
  - Different signs: compare magnitudes and subtract the smaller from the larger; result sign = sign of the larger. If the magnitudes are equal, the result sign is +.
- FIX:
  - Saturation: if the sum bit M is set, magnitude = 2^M−1, `ovf`=1, and the sign is preserved.
  - Zero: a zero magnitude forces sign = 0 (no −0 output); `zero`=1.
  - Registers `result`, `zero`, `neg` and `ovf`.
- −0 inputs are treated as +0.
- `start` while in EXEC or FIX is ignored; there is no queuing.
- `acc`=1 uses the registered `result` value, which is 0 after reset.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `zero`=0, `neg`=0, `ovf`=0, state = IDLE.
- Acceptance: `start`=1 in IDLE or DONE at rising edge E0.
- `busy`=1 after E0 and remains high through EXEC and FIX.
- Latency: `done`=1 and outputs update after edge E2, i.e. 3 edges including the acceptance edge.
- `done` is high for exactly one cycle, and `busy`=0 in that cycle.
- Back-to-back: `start` held high in DONE gives one result every 3 cycles.
- `result` and flags change only at the edge entering DONE; they are stable otherwise.
- Reset asserted mid-operation: immediately returns to IDLE and clears all outputs; no `done` for the aborted operation.

## Structure
- Shared package `sm_arith_pkg` contains:
  - the state enum (IDLE, EXEC, FIX, DONE);
  - localparams for the op encoding (OP_ADD=0, OP_SUB=1);
  - a helper function returning magnitude max (2^(W−1)−1).
- One sub-module, `sm_mag_core`:
  - Combinational and parametrised on W.
  - Inputs: magnitudes and signs.
  - Outputs: M+1-bit magnitude, sign and carry.
  - It is registered by the top at EXEC.
- Top module holds the FSM, operand registers and output registers.

## Test plan
All scenarios use W=8.
- a=+5 (0x05), b=+3, op_sub=0 → after 3 edges `done`, result=0x08, zero=0, neg=0, ovf=0.
- a=+5, b=+7 (0x07), op_sub=1 → result=0x82 (−2), neg=1.
- a=−3 (0x83), b=+3, op_sub=0 → result=0x00, zero=1, neg=0; also a=0x80, b=0x00 → result=0x00.
- a=+100 (0x64), b=+50, op_sub=0 → result=0x7F, ovf=1. Then a=−100, b=−50 → result=0xFF, ovf=1.
- Accumulate sequence with `start` held in DONE:
  - +10 (acc=0), then b=+5 (acc=1), then b=+20 with op_sub=1 (acc=1).
  - Results: 0x0A, 0x0F, 0x85; `done` pulses every 3 cycles.
- Abort and busy checks:
  - Pulse `start` during EXEC → ignored; only one `done`.
  - Assert `rst_n`=0 in FIX → outputs 0, no `done`.
  - Next `start` after reset works normally.

Source files
------------

// File: rtl/sm_arith_pkg.sv
// Shared types and constants for the sign-magnitude add/sub datapath.
// Holds the sequencer state encoding, op encoding and magnitude limit helper.
package sm_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Largest magnitude representable in a w-bit sign-magnitude word.
    function automatic int unsigned mag_max(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sm_addsub_seq_if.sv
// Request/result bundle between a controller and the sign-magnitude add/sub unit.
// start is sampled only while busy is low; done pulses once per accepted request.
interface sm_addsub_seq_if #(parameter int W = 8);

    logic         start;
    logic         op_sub;
    logic         acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         neg;
    logic         ovf;

    modport master (
        output start, op_sub, acc, a, b,
        input  busy, done, result, zero, neg, ovf
    );

    modport slave (
        input  start, op_sub, acc, a, b,
        output busy, done, result, zero, neg, ovf
    );

endinterface

// File: rtl/sm_mag_core.sv
// Combinational sign-magnitude add/sub core; zero latency, no flow control.
// Produces an M+1-bit magnitude so the caller can detect and saturate overflow.
module sm_mag_core #(
    parameter int W = 8
) (
    input  logic [W-2:0] mag_a,
    input  logic [W-2:0] mag_b,
    input  logic         sgn_a,
    input  logic         sgn_b,
    output logic [W-1:0] mag_o,
    output logic         sgn_o,
    output logic         carry
);

    localparam int M = W - 1;

    always_comb begin
        mag_o = '0;
        sgn_o = 1'b0;
        if (sgn_a == sgn_b) begin
            mag_o = {1'b0, mag_a} + {1'b0, mag_b};
            sgn_o = sgn_a;
        end else if (mag_a > mag_b) begin
            mag_o = {1'b0, mag_a - mag_b};
            sgn_o = sgn_a;
        end else if (mag_b > mag_a) begin
            mag_o = {1'b0, mag_b - mag_a};
            sgn_o = sgn_b;
        end
        // Equal magnitudes with opposite signs fall through to +0.
    end

    assign carry = mag_o[M];

endmodule

// File: rtl/sm_addsub_seq.sv
// Registered sign-magnitude add/sub with accumulate and saturation; done 3 edges after accept.
// No queuing: start is only honoured in IDLE or DONE, so one result per 3 cycles back-to-back.
module sm_addsub_seq
    import sm_arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sm_addsub_seq_if.slave    bus
);

    localparam int M = W - 1;
    localparam logic [M-1:0] MAG_MAX = M'(mag_max(W));

    state_t       state;
    logic         busy_q;
    logic         done_q;
    logic [W-1:0] res_q;
    logic         zero_q;
    logic         neg_q;
    logic         ovf_q;

    logic [M-1:0] opa_mag, opb_mag;
    logic         opa_sgn, opb_sgn;
    logic [M-1:0] sum_mag_q;
    logic         sum_sgn_q;
    logic         carry_q;

    logic [M-1:0] cap_a_mag, cap_b_mag;
    logic         cap_a_sgn, cap_b_sgn;

    logic [W-1:0] core_mag;
    logic         core_sgn;
    logic         core_carry;

    logic [M-1:0] fix_mag;
    logic         fix_zero;
    logic         fix_neg;

    // Operand selection at the accepting edge; -0 is folded to +0 here.
    always_comb begin
        cap_a_mag = bus.acc ? res_q[M-1:0] : bus.a[M-1:0];
        cap_a_sgn = bus.acc ? res_q[W-1]   : bus.a[W-1];
        cap_b_mag = bus.b[M-1:0];
        cap_b_sgn = bus.b[W-1];
        case (bus.op_sub)
            OP_ADD:  cap_b_sgn = bus.b[W-1];
            OP_SUB:  cap_b_sgn = ~bus.b[W-1];
            default: cap_b_sgn = bus.b[W-1];
        endcase
        if (cap_a_mag == '0) cap_a_sgn = 1'b0;
        if (cap_b_mag == '0) cap_b_sgn = 1'b0;
    end

    sm_mag_core #(.W(W)) u_core (
        .mag_a (opa_mag),
        .mag_b (opb_mag),
        .sgn_a (opa_sgn),
        .sgn_b (opb_sgn),
        .mag_o (core_mag),
        .sgn_o (core_sgn),
        .carry (core_carry)
    );

    always_comb begin
        fix_mag  = carry_q ? MAG_MAX : sum_mag_q;
        fix_zero = (fix_mag == '0);
        fix_neg  = sum_sgn_q & ~fix_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            opa_mag   <= '0;
            opb_mag   <= '0;
            opa_sgn   <= 1'b0;
            opb_sgn   <= 1'b0;
            sum_mag_q <= '0;
            sum_sgn_q <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        opa_mag <= cap_a_mag;
                        opa_sgn <= cap_a_sgn;
                        opb_mag <= cap_b_mag;
                        opb_sgn <= cap_b_sgn;
                        busy_q  <= 1'b1;
                        state   <= EXEC;
                    end else begin
                        state   <= IDLE;
                    end
                end
                EXEC: begin
                    sum_mag_q <= core_mag[M-1:0];
                    sum_sgn_q <= core_sgn;
                    carry_q   <= core_carry;
                    state     <= FIX;
                end
                FIX: begin
                    res_q  <= {fix_neg, fix_mag};
                    zero_q <= fix_zero;
                    neg_q  <= fix_neg;
                    ovf_q  <= carry_q;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.zero   = zero_q;
    assign bus.neg    = neg_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_sm_addsub_seq.sv
// Directed bench for sm_addsub_seq at W=8: arithmetic, saturation, accumulate, abort.
module tb_sm_addsub_seq;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] last_res;

    logic [7:0] bt_a  [3] = '{8'h0A, 8'h00, 8'h00};
    logic [7:0] bt_b  [3] = '{8'h00, 8'h05, 8'h14};
    logic       bt_sub[3] = '{1'b0, 1'b0, 1'b1};
    logic       bt_acc[3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] bt_res[3] = '{8'h0A, 8'h0F, 8'h85};

    sm_addsub_seq_if #(.W(8)) bus ();

    sm_addsub_seq #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] r, input logic z, input logic n, input logic o);
        chk({tag, ".result"}, bus.result, r);
        chk({tag, ".zero"},   bus.zero,   z);
        chk({tag, ".neg"},    bus.neg,    n);
        chk({tag, ".ovf"},    bus.ovf,    o);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic acc,
                          input logic [7:0] er, input logic ez, input logic en, input logic eo);
        @(negedge clk);
        chk({tag, ".pre_done"}, bus.done, 1'b0);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.op_sub = sub; bus.acc = acc;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, ".exec_busy"}, bus.busy, 1'b1);
        chk({tag, ".exec_done"}, bus.done, 1'b0);
        chk({tag, ".exec_hold"}, bus.result, last_res);
        @(negedge clk);
        chk({tag, ".fix_busy"}, bus.busy, 1'b1);
        chk({tag, ".fix_hold"}, bus.result, last_res);
        @(negedge clk);
        chk({tag, ".done"}, bus.done, 1'b1);
        chk({tag, ".done_busy"}, bus.busy, 1'b0);
        chk_outs(tag, er, ez, en, eo);
        last_res = er;
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op_sub = 1'b0; bus.acc = 1'b0; bus.a = '0; bus.b = '0;
        last_res = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.done", bus.done, 1'b0);
        chk_outs("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        run_op("add",   8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        run_op("sub",   8'h05, 8'h07, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1, 1'b0);
        run_op("cancel",8'h83, 8'h03, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("negz",  8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("satp",  8'h64, 8'h32, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        run_op("satn",  8'hE4, 8'hB2, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);

        // Back-to-back accumulate with start held through DONE.
        @(negedge clk);
        bus.start = 1'b1; bus.a = bt_a[0]; bus.b = bt_b[0];
        bus.op_sub = bt_sub[0]; bus.acc = bt_acc[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b.exec_busy", bus.busy, 1'b1);
            chk("b2b.exec_done", bus.done, 1'b0);
            if (k < 2) begin
                bus.a = bt_a[k+1]; bus.b = bt_b[k+1];
                bus.op_sub = bt_sub[k+1]; bus.acc = bt_acc[k+1];
            end
            @(negedge clk);
            chk("b2b.fix_done", bus.done, 1'b0);
            @(negedge clk);
            chk("b2b.done", bus.done, 1'b1);
            chk("b2b.result", bus.result, bt_res[k]);
            if (k == 2) bus.start = 1'b0;
        end
        chk("b2b.neg", bus.neg, 1'b1);
        @(negedge clk);
        chk("b2b.idle_done", bus.done, 1'b0);
        chk("b2b.idle_busy", bus.busy, 1'b0);
        bus.acc = 1'b0; bus.op_sub = 1'b0;

        // start pulsed during EXEC must be ignored.
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
        @(negedge clk);
        bus.a = 8'h10; bus.b = 8'h10;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign.fix_busy", bus.busy, 1'b1);
        count_done(5, cnt);
        chk("ign.done_count", cnt, 1);
        chk("ign.result", bus.result, 8'h02);

        // Reset asserted in FIX aborts the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h02; bus.b = 8'h02;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", bus.busy, 1'b0);
        chk("abort.done", bus.done, 1'b0);
        chk_outs("abort", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(4, cnt);
        chk("abort.done_count", cnt, 0);
        last_res = 8'h00;

        run_op("acc_rst", 8'h55, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        run_op("post",    8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
